adc_lvds_tx_pattern: RTL and testbench

//  Transmit-side counterpart of the ADC differential data-input buffering: drives DATA_WIDTH

---
 rtl/adc_lvds_tx_pattern.sv | 165 ++++++++++++++++
 tb/tb_adc_lvds_tx_pattern.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_lvds_tx_pattern.sv
// adc_lvds_tx_pattern
// Transmit-side LVDS pattern source: sends a training sequence after reset or on
// request, then streams words from a small FIFO onto DATA_WIDTH differential lanes.
// When no data is queued, the lanes carry IDLE_WORD.
module adc_lvds_tx_pattern #(
  parameter int                    DATA_WIDTH    = 10,
  parameter int                    FIFO_DEPTH    = 16,
  parameter int                    TRAIN_WORDS   = 64,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 'h2AA,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = '0,
  // Saturation value of underflow_cnt; full 16-bit range by default.
  parameter logic [15:0]           UNDERFLOW_MAX = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          train_req,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         dout_p,
  output logic [DATA_WIDTH-1:0]         dout_n,
  output logic [DATA_WIDTH-1:0]         dout_word,
  output logic                          training,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(TRAIN_WORDS);

  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [IW-1:0] TRAIN_LAST = IW'(TRAIN_WORDS - 1);

  typedef enum logic [1:0] {
    S_TRAIN  = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [IW-1:0]         idx, idx_next;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  pop;
  logic                  push;
  logic                  uf_inc;
  logic                  fifo_empty;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head;

  // Ready depends only on the registered occupancy, never on this cycle's pop.
  assign s_ready    = (fifo_level < DEPTH_L) && !rst;
  assign push       = s_valid && s_ready;
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];
  assign training   = (state == S_TRAIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_TRAIN;
    end else begin
      // NOTE: clocked state always uses non-blocking assignment so every register
      // samples the pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state decode; train_req overrides every state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    if (train_req) begin
      state_next = S_TRAIN;
    end else begin
      unique case (state)
        S_TRAIN:  if (idx == TRAIN_LAST) state_next = S_IDLE;
        S_IDLE:   if (!fifo_empty)       state_next = S_STREAM;
        S_STREAM: if (fifo_empty)        state_next = S_IDLE;
        default:                         state_next = S_TRAIN;
      endcase
    end
  end

  // Output decode: next lane word, FIFO pop, training index and underflow strobe.
  always_comb begin
    word_next = IDLE_WORD;
    idx_next  = idx;
    pop       = 1'b0;
    uf_inc    = 1'b0;
    if (train_req) begin
      // Restart sends index 0 on this very edge; the index is not advanced, so the
      // following cycle sends index 0 again as the first word of the full sequence.
      word_next = TRAIN_PATTERN;
      idx_next  = '0;
    end else begin
      unique case (state)
        S_TRAIN: begin
          word_next = idx[0] ? ~TRAIN_PATTERN : TRAIN_PATTERN;
          idx_next  = (idx == TRAIN_LAST) ? '0 : idx + 1'b1;
        end
        S_IDLE, S_STREAM: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            word_next = head;
          end else if (state == S_STREAM) begin
            uf_inc = 1'b1;
          end
        end
        default: word_next = IDLE_WORD;
      endcase
    end
  end

  // Lane word, training index and underflow counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_word     <= IDLE_WORD;
      idx           <= '0;
      underflow_cnt <= '0;
    end else begin
      dout_word <= word_next;
      idx       <= idx_next;
      if (uf_inc && (underflow_cnt != UNDERFLOW_MAX)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers and occupancy define validity,
    // which keeps the array mappable to plain RAM.
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers (wrap modulo depth) and occupancy (extra MSB separates full from empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Differential lane drivers: behavioural equivalent of one OBUFDS per lane
  // (O follows the input, OB its complement).
  for (genvar lane = 0; lane < DATA_WIDTH; lane++) begin : g_lane
    assign dout_p[lane] = dout_word[lane];
    assign dout_n[lane] = ~dout_word[lane];
  end

endmodule

// File: tb/tb_adc_lvds_tx_pattern.sv
// Testbench for adc_lvds_tx_pattern: randomized traffic with a queue-based
// reference model; a negedge monitor pops expected outputs and compares.
module tb_adc_lvds_tx_pattern;

  localparam int          DW    = 10;
  localparam int          DEPTH = 16;
  localparam int          TW    = 64;
  localparam logic [DW-1:0] PAT  = 10'h2AA;
  localparam logic [DW-1:0] IDLE = 10'h000;
  localparam logic [15:0]   UFMAX = 16'd20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          train_req;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] dout_p, dout_n, dout_word;
  logic          training;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]   underflow_cnt;

  adc_lvds_tx_pattern #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .TRAIN_WORDS  (TW),
    .TRAIN_PATTERN(PAT),
    .IDLE_WORD    (IDLE),
    .UNDERFLOW_MAX(UFMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .train_req    (train_req),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dout_p       (dout_p),
    .dout_n       (dout_n),
    .dout_word    (dout_word),
    .training     (training),
    .fifo_level   (fifo_level),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    logic          training;
    int            level;
    logic [15:0]   uf;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_fifo[$];
  int            train_pos;   // position in training sequence, -1 when not training
  bit            streaming;   // last output word came from the FIFO
  logic [DW-1:0] m_word;
  logic [15:0]   m_uf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one step per clock edge, reset clears everything at once.
  task automatic model_step();
    exp_t r;
    int   lvl;
    bit   push;
    if (rst) begin
      ref_fifo.delete();
      exp_q.delete();
      train_pos = 0;
      streaming = 0;
      m_word    = IDLE;
      m_uf      = '0;
    end else begin
      lvl  = ref_fifo.size();
      push = s_valid && (lvl < DEPTH);
      if (train_req) begin
        m_word    = PAT;
        train_pos = 0;
        streaming = 0;
      end else if (train_pos >= 0) begin
        m_word    = (train_pos % 2 == 0) ? PAT : ~PAT;
        train_pos = (train_pos == TW - 1) ? -1 : train_pos + 1;
      end else if (lvl > 0) begin
        m_word    = ref_fifo.pop_front();
        streaming = 1;
      end else begin
        m_word = IDLE;
        if (streaming && m_uf != UFMAX) m_uf = m_uf + 16'd1;
        streaming = 0;
      end
      if (push) ref_fifo.push_back(s_data);
    end
    r.word     = m_word;
    r.training = (train_pos >= 0);
    r.level    = ref_fifo.size();
    r.uf       = m_uf;
    exp_q.push_back(r);
  endtask

  always @(posedge clk or posedge rst) model_step();

  // Monitor: pop one expectation per cycle and compare all outputs.
  always @(negedge clk) begin
    exp_t          r;
    logic [DW-1:0] nw;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty at %0t: got no expectation, expected one", $time);
    end else begin
      r  = exp_q.pop_front();
      nw = ~r.word;
      check("dout_word",     32'(dout_word),     32'(r.word));
      check("dout_p",        32'(dout_p),        32'(r.word));
      check("dout_n",        32'(dout_n),        32'(nw));
      check("training",      32'(training),      32'(r.training));
      check("fifo_level",    32'(fifo_level),    32'(r.level));
      check("underflow_cnt", 32'(underflow_cnt), 32'(r.uf));
      check("s_ready",       32'(s_ready),       32'((r.level < DEPTH) && !rst));
    end
  end

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic t);
    s_valid   = v;
    s_data    = d;
    train_req = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, DW'($urandom), 1'b0);
  endtask

  initial begin
    s_valid   = 1'b0;
    s_data    = '0;
    train_req = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Training after reset, then idle.
    repeat (70) idle_cycle();

    // Three consecutive words then underflow.
    for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i), 1'b0);
    repeat (10) idle_cycle();

    // Fill FIFO while training is held by repeated requests, then drain.
    repeat (30) cycle(1'b1, DW'($urandom), 1'b1);
    repeat (100) idle_cycle();

    // Queue words during training, restart training mid-stream.
    cycle(1'b0, '0, 1'b1);
    repeat (10) cycle(1'b1, DW'($urandom), 1'b0);
    repeat (60) idle_cycle();
    cycle(1'b0, '0, 1'b1);
    repeat (100) idle_cycle();

    // Random traffic with occasional training requests.
    repeat (400) cycle(1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 49) == 0);
    repeat (90) idle_cycle();

    // Reset in the middle of streaming.
    repeat (6) cycle(1'b1, DW'($urandom), 1'b0);
    repeat (2) idle_cycle();
    rst = 1'b1;
    #1;
    check("rst_async_word",  32'(dout_word),  32'(IDLE));
    check("rst_async_level", 32'(fifo_level), 32'd0);
    check("rst_async_ready", 32'(s_ready),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (75) idle_cycle();

    // Repeated single-word underflows drive the counter into saturation.
    repeat (30) begin
      cycle(1'b1, DW'($urandom), 1'b0);
      idle_cycle();
      idle_cycle();
    end
    repeat (3) idle_cycle();
    check("uf_saturated", 32'(underflow_cnt), 32'(UFMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
